// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder with an event FIFO for the MIO keyboard port.
// Prefix bytes (E0 / F0 / E1) are folded into single {brk, ext, code} events.
// The events are queued in a first-word-fall-through FIFO that the CPU pops.
module ps2_scan_decoder #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic                     clk,
    input  logic                     RSTN,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [9:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [2:0]      skip_q, skip_d;
    logic            push_req;
    logic [9:0]      push_data;
    logic            is_prefix;

    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q;
    logic [9:0]      dout_q;
    logic            ovf_q;
    logic            do_pop, do_push, drop;

    assign is_prefix = (byte_in == 8'hE0) || (byte_in == 8'hF0) || (byte_in == 8'hE1);

    // Decoder state, prefix timeout counter and Pause skip counter
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            skip_q  <= skip_d;
        end
    end

    // Next-state logic: byte consumption takes priority over the timeout
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        skip_d    = skip_q;
        push_req  = 1'b0;
        push_data = '0;
        if (byte_valid) begin
            tcnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    case (byte_in)
                        8'hE0: state_d = S_EXT;
                        8'hF0: state_d = S_BRK;
                        8'hE1: begin
                            state_d = S_PAUSE;
                            skip_d  = 3'd7;
                        end
                        // Keyboard acks / self-test / echo / resend / errors
                        8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        default: begin
                            push_req  = 1'b1;
                            push_data = {2'b00, byte_in};
                        end
                    endcase
                end
                S_EXT: begin
                    if (byte_in == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (byte_in != 8'hE0 && byte_in != 8'hE1) begin
                        push_req  = 1'b1;
                        push_data = {2'b01, byte_in};
                        state_d   = S_IDLE;
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (!is_prefix) begin
                        push_req  = 1'b1;
                        push_data = {2'b10, byte_in};
                    end
                end
                S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (!is_prefix) begin
                        push_req  = 1'b1;
                        push_data = {2'b11, byte_in};
                    end
                end
                S_PAUSE: begin
                    if (skip_q == 3'd1) begin
                        push_req  = 1'b1;
                        push_data = {2'b01, 8'hE1};
                        state_d   = S_IDLE;
                        skip_d    = '0;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = S_IDLE;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge
    assign do_pop  = rd_en && (cnt_q != '0);
    assign do_push = push_req && ((cnt_q != CW'(DEPTH)) || do_pop);
    assign drop    = push_req && !do_push;

    // FIFO storage (no reset needed; validity tracked by the count)
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= push_data;
        end
    end

    // FIFO pointers, count, registered head entry and sticky overflow flag
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            // Head is kept in a register so it holds its last value once drained
            if (do_push && ((cnt_q == '0) || (cnt_q == CW'(1) && do_pop))) begin
                dout_q <= push_data;
            end else if (do_pop && (cnt_q > CW'(1))) begin
                dout_q <= mem[rptr_q + AW'(1)];
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign dout  = dout_q;
    assign count = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed testbench for ps2_scan_decoder (DEPTH=8, short prefix timeout).
module tb_ps2_scan_decoder;

    logic       clk;
    logic       RSTN;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       rd_en;
    logic       clr_ovf;
    logic [9:0] dout;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       ovf;

    int n_asserts = 0;
    int n_fails   = 0;

    ps2_scan_decoder #(
        .DEPTH       (8),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk        (clk),
        .RSTN       (RSTN),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .rd_en      (rd_en),
        .clr_ovf    (clr_ovf),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .ovf        (ovf)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle byte strobe; inputs change on the falling edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_head;

        RSTN       = 1'b0;
        byte_in    = '0;
        byte_valid = 1'b0;
        rd_en      = 1'b0;
        clr_ovf    = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_dout",  32'(dout),  32'h000);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        RSTN = 1'b1;

        // Reset mid-sequence drops the partial E0 F0 prefix
        send(8'hE0);
        send(8'hF0);
        @(negedge clk);
        RSTN = 1'b0;
        @(negedge clk);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ovf",   32'(ovf),   32'd0);
        RSTN = 1'b1;
        send(8'h1C);
        chk("midrst_dout",  32'(dout),  32'h01C);
        chk("midrst_cnt1",  32'(count), 32'd1);
        pop();
        chk("midrst_drain", 32'(empty), 32'd1);

        // Plain make then break
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        chk("plain_count", 32'(count), 32'd2);
        chk("plain_head0", 32'(dout),  32'h01C);
        pop();
        chk("plain_head1", 32'(dout),  32'h21C);
        pop();
        chk("plain_empty", 32'(empty), 32'd1);

        // Extended make/break with acks filtered out in IDLE
        send(8'hFA);
        send(8'hE0);
        send(8'h75);
        send(8'hFA);
        send(8'hAA);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("ext_count", 32'(count), 32'd2);
        chk("ext_head0", 32'(dout),  32'h175);
        pop();
        chk("ext_head1", 32'(dout),  32'h375);
        pop();
        chk("ext_empty", 32'(empty), 32'd1);

        // Pause sequence collapses to one event
        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        chk("pause_pending", 32'(count), 32'd0);
        send(8'h77);
        chk("pause_count", 32'(count), 32'd1);
        chk("pause_head",  32'(dout),  32'h1E1);
        pop();

        // Abandoned break prefix times out; next byte is a plain make
        send(8'hF0);
        repeat (100) @(negedge clk);
        send(8'h1C);
        chk("tmo_count", 32'(count), 32'd1);
        chk("tmo_head",  32'(dout),  32'h01C);
        send(8'h1D);
        chk("tmo_idle",  32'(count), 32'd2);
        pop();
        pop();
        chk("tmo_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, then one more push gets dropped
        for (int unsigned i = 1; i <= 8; i++) send(8'(i));
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_ovf",   32'(ovf),   32'd0);
        send(8'h09);
        chk("ovf_set",   32'(ovf),   32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_head",  32'(dout),  32'h001);

        // Clear the sticky flag
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);

        // Push and pop together while full: both land, no drop
        @(negedge clk);
        byte_in    = 8'h0A;
        byte_valid = 1'b1;
        rd_en      = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        rd_en      = 1'b0;
        chk("pp_count", 32'(count), 32'd8);
        chk("pp_full",  32'(full),  32'd1);
        chk("pp_ovf",   32'(ovf),   32'd0);

        // Drain: 002..008 then 00A; 009 never entered
        for (int unsigned i = 0; i < 8; i++) begin
            exp_head = (i < 7) ? 10'(i + 2) : 10'h00A;
            chk($sformatf("drain_head%0d", i), 32'(dout), 32'(exp_head));
            pop();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);

        // Pop while empty is ignored
        pop();
        chk("under_empty", 32'(empty), 32'd1);
        chk("under_count", 32'(count), 32'd0);
        chk("under_full",  32'(full),  32'd0);

        // Drop and clear in the same cycle: the drop wins
        for (int unsigned i = 1; i <= 8; i++) send(8'(i + 8'h10));
        @(negedge clk);
        byte_in    = 8'h20;
        byte_valid = 1'b1;
        clr_ovf    = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        clr_ovf    = 1'b0;
        chk("drop_wins_ovf",  32'(ovf),   32'd1);
        chk("drop_wins_head", 32'(dout),  32'h011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
